// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
// Holds the ID/EX register through stall_req while iterating; done pulses for one cycle with result.
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  div_op,
  input  logic [31:0] src_j,
  input  logic [31:0] src_k,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] src_j_q;
  logic        mod_q, q_neg_q, r_neg_q, dz_q;
  logic [31:0] result_q;

  logic        sgn_op;
  logic        accept;
  logic        last;
  logic [31:0] abs_j, abs_k;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        ge;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] res_fix;

  assign sgn_op = ~div_op[1];
  assign accept = (state_q == IDLE) & start & ~flush;
  assign last   = (cnt_q == 6'd31);
  assign abs_j  = (sgn_op & src_j[31]) ? -src_j : src_j;
  assign abs_k  = (sgn_op & src_k[31]) ? -src_k : src_k;

  // A set top remainder bit means the shifted value already exceeds any 32-bit divisor.
  assign rem_sh = {rem_q[31:0], quo_q[31]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign ge     = rem_q[32] | ~trial[33];
  assign rem_nx = ge ? trial[32:0] : rem_sh;
  assign quo_nx = {quo_q[30:0], ge};

  always_comb begin
    res_fix = 32'h0;
    if (dz_q)
      res_fix = mod_q ? src_j_q : 32'hFFFF_FFFF;
    else if (mod_q)
      res_fix = r_neg_q ? -rem_nx[31:0] : rem_nx[31:0];
    else
      res_fix = q_neg_q ? -quo_nx : quo_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 6'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      src_j_q  <= 32'd0;
      mod_q    <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= 32'd0;
    end else begin
      if (accept) begin
        mod_q   <= div_op[0];
        quo_q   <= abs_j;
        dvs_q   <= abs_k;
        src_j_q <= src_j;
        q_neg_q <= sgn_op & (src_j[31] ^ src_k[31]);
        r_neg_q <= sgn_op & src_j[31];
        dz_q    <= (src_k == 32'd0);
        cnt_q   <= 6'd0;
        rem_q   <= 33'd0;
      end else if (state_q == CALC) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 6'd1;
        if (last && !flush) result_q <= res_fix;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign stall_req = accept | (state_q == CALC);
  assign result    = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: latency, stall window, sign/corner results, flush, re-trigger.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] src_j = 32'd0;
  logic [31:0] src_k = 32'd0;
  logic        busy, stall_req, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  ex_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .div_op(div_op),
    .src_j(src_j), .src_k(src_k), .busy(busy), .stall_req(stall_req),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents start in IDLE, returns just after the accepting edge E0.
  task automatic launch(input logic [1:0] op, input logic [31:0] j, input logic [31:0] k);
    div_op = op; src_j = j; src_k = k; start = 1'b1;
    #1 chk("acc_stall", {31'd0, stall_req}, 32'd1);
    tick;
    start = 1'b0;
  endtask

  // Runs to the DONE cycle; cyc0 = edges since the accept cycle already consumed.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int cyc0);
    int cyc = cyc0;
    int st  = cyc0;
    while (!done && cyc < 100) begin
      if (stall_req) st++;
      tick;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 33);
    chk({tag, "_stallcnt"}, st, 33);
    chk({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_res"}, result, exp);
  endtask

  task automatic after_done(input string tag);
    tick;
    chk({tag, "_done1"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] j,
                     input logic [31:0] k, input logic [31:0] exp);
    launch(op, j, k);
    finish_op(tag, exp, 1);
    after_done(tag);
  endtask

  initial begin
    bit seen;
    // Reset and idle
    tick; tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    rst = 1'b0;
    start = 1'b1; flush = 1'b1;
    #1 chk("sf_stall", {31'd0, stall_req}, 32'd0);
    tick;
    chk("sf_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // Basic, sign, corner
    run("divw",     2'b00, 32'd100,        32'd7,          32'd14);
    run("modw",     2'b01, 32'd100,        32'd7,          32'd2);
    run("divw_neg", 2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    run("modw_neg", 2'b01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    run("divwu",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC);
    run("modwu",    2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1);
    run("modw_nk",  2'b01, 32'd7,          32'hFFFF_FFFE,  32'd1);
    run("divw_dz",  2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF);
    run("modwu_dz", 2'b11, 32'd5,          32'd0,          32'd5);
    run("divw_ovf", 2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run("modw_ovf", 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);

    // Flush mid-operation: result keeps 0 from modw_ovf
    launch(2'b10, 32'd1000, 32'd3);
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_stall", {31'd0, stall_req}, 32'd0);
    chk("fl_result", result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      tick;
    end
    chk("fl_nodone", {31'd0, seen}, 32'd0);
    chk("fl_result2", result, 32'd0);
    run("fl_rerun", 2'b10, 32'd1000, 32'd3, 32'd333);

    // Operand change and start pulse during CALC are ignored
    launch(2'b00, 32'd100, 32'd7);
    repeat (4) tick;
    src_j = 32'd50; src_k = 32'd5; div_op = 2'b10; start = 1'b1;
    tick;
    start = 1'b0;
    finish_op("stab", 32'd14, 6);

    // Start in DONE ignored, accepted in the following IDLE cycle
    div_op = 2'b10; src_j = 32'd20; src_k = 32'd4; start = 1'b1;
    tick;
    chk("rt_busy", {31'd0, busy}, 32'd0);
    chk("rt_done", {31'd0, done}, 32'd0);
    chk("rt_stall", {31'd0, stall_req}, 32'd1);
    tick;
    start = 1'b0;
    chk("rt_acc", {31'd0, busy}, 32'd1);
    finish_op("retrig", 32'd5, 1);
    after_done("retrig");

    // Reset mid-operation clears result
    launch(2'b00, 32'd100, 32'd7);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_result", result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit integer divider in the EX stage. Consumes the forwarded rj/rk operands and decoded opcode held in the ID/EX pipeline register and executes DIV.W, MOD.W, DIV.WU and MOD.WU with a radix-2 restoring algorithm. While it runs, it raises a stall request that holds the ID/EX register (wen low). The result is returned to the EX result mux with a one-cycle done pulse.

## Interface
Parameters:
- none; the width is fixed at 32 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a divide. Sampled only in IDLE.
- flush  in  1  pipeline flush. Aborts any operation in progress.
- div_op  in  2  operation select: 00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU.
- src_j  in  32  dividend (rj after forwarding).
- src_k  in  32  divisor (rk after forwarding).
- busy  out  1  high whenever state is not IDLE.
- stall_req  out  1  combinational. Equals (start & ~flush & IDLE) | CALC.
- done  out  1  registered. High for exactly one cycle (the DONE state).
- result  out  32  registered quotient or remainder. Valid while done is high; held until the next completion.

## Operation
- States:
  - IDLE: entered after rst.
  - CALC: 32 iterations.
  - DONE: 1 cycle, then returns to IDLE unconditionally.
- Leaving IDLE: when start=1 and flush=0, the unit latches
  - the op,
  - the dividend and divisor magnitudes (absolute value for signed ops; the raw value for unsigned ops),
  - the quotient sign = src_j[31]^src_k[31] (signed ops only),
  - the remainder sign = src_j[31] (signed ops only),
  - a divide-by-zero flag (src_k==0).
  
  It then clears the 6-bit iteration counter and the 33-bit partial remainder, and moves to CALC.
- Each CALC cycle (restoring step):
  - shift {rem, dividend} left by 1;
  - trial = rem - divisor;
  - if the trial is non-negative, rem = trial and the quotient bit is 1, else the quotient bit is 0;
  - increment the counter.
- Last CALC step (counter==31): the corrected value is registered into result, and the state moves to DONE.
- Sign correction:
  - the quotient is negated when the quotient sign is 1;
  - the remainder is negated when the remainder sign is 1.
  - Unsigned ops are never negated.
- Divide by zero overrides the algorithm, for all four ops:
  - DIV/DIV.WU → 0xFFFFFFFF;
  - MOD/MOD.WU → the latched original src_j.
- Signed overflow 0x80000000 / 0xFFFFFFFF: DIV.W → 0x80000000, MOD.W → 0. This falls out of the magnitude arithmetic; no special case is needed.
- start is ignored while busy. Operands are latched at acceptance, so later changes on src_j/src_k have no effect.
- flush, in any state: the next state is IDLE, no done pulse occurs, and result is unchanged. If start and flush are high in the same cycle in IDLE, flush wins: nothing starts and stall_req=0.
- rst mid-operation: behaves like flush, and additionally clears result.

## Timing
- Reset values:
  - registered outputs: busy=0, done=0, result=0x00000000;
  - internal: state=IDLE, counter=0.
  - stall_req then follows its combinational definition.
- Latency: start is accepted at edge E0. CALC occupies the 32 cycles following E0. result is written at edge E32, and done=1 in the cycle after E32. That is 33 cycles from acceptance to done. The next start can be accepted in the cycle after DONE.
- stall_req:
  - high in the accept cycle and in all CALC cycles;
  - low in DONE, so ID/EX advances at the edge ending DONE while the EX stage consumes result.
- Back-to-back divides: a second start presented in DONE is ignored. It must be presented again in IDLE.
- flush during CALC at edge Ef: busy=0 and stall_req=0 in the cycle after Ef.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 2 cycles.
  - Required: busy=0, done=0, result=0, stall_req=0.
  - Stimulus: start=1 with flush=1.
  - Required: stays in IDLE, stall_req=0.
- Basic unsigned and signed divide:
  - DIV.W 100/7 → done exactly 33 cycles after acceptance, result=14. stall_req was high for 33 cycles and drops in DONE.
  - MOD.W 100/7 → 2.
- Sign handling:
  - DIV.W 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - MOD.W 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - DIV.WU 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - MOD.WU 0xFFFFFFF9/2 → 1.
  - MOD.W 7/0xFFFFFFFE → 1.
- Corner operands:
  - DIV.W 5/0 → 0xFFFFFFFF.
  - MOD.WU 5/0 → 5.
  - DIV.W 0x80000000/0xFFFFFFFF → 0x80000000.
  - MOD.W of the same operands → 0.
- Flush mid-operation:
  - Stimulus: start DIV.WU 1000/3, flush on CALC cycle 10.
  - Required: busy=0 on the next cycle, no done pulse, result keeps its previous value.
  - Stimulus: then start DIV.WU 1000/3 again.
  - Required: result=333 after 33 cycles.
- Operand stability and re-trigger:
  - Stimulus: change src_j/src_k and pulse start during CALC.
  - Required: the result reflects the original operands and no second operation runs.
  - Stimulus: present start again in DONE.
  - Required: it is ignored; the same start in the following IDLE cycle is accepted.
